// File: rtl/pwm_multi_avs_if.sv
// Avalon-MM slave bus bundle for the multi-channel PWM block.
// The master drives address/strobes/data; the slave returns readdata and waitrequest.
interface pwm_multi_avs_if;
    logic [7:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/pwm_multi_avs.sv
// Multi-channel PWM generator with prescaler, edge/center alignment and
// shadowed period/duty registers, controlled over an Avalon-MM slave port.
module pwm_multi_avs #(
    parameter int CH_COUNT  = 8,
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    pwm_multi_avs_if.slave      avs_s0,
    output logic [CH_COUNT-1:0] pwm_out,
    output logic                period_irq
);

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PERIOD   = 8'h01;
    localparam logic [7:0] ADDR_PRESCALE = 8'h02;
    localparam logic [7:0] ADDR_STATUS   = 8'h03;
    localparam logic [7:0] ADDR_CH_EN    = 8'h04;
    localparam logic [7:0] ADDR_DUTY0    = 8'h10;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    rd_state_t rd_state, rd_state_next;
    logic      rd_capture;
    logic [31:0] rd_mux, readdata_q;

    logic                 en, center, inv;
    logic [CNT_WIDTH-1:0] period_sh, p_act;
    logic [PRE_WIDTH-1:0] prescale, pre_cnt;
    logic [CH_COUNT-1:0]  ch_en;
    logic [CNT_WIDTH-1:0] duty_sh [CH_COUNT];
    logic [CNT_WIDTH-1:0] d_act   [CH_COUNT];
    logic                 pending, center_act, dir_down;
    logic [CNT_WIDTH-1:0] cnt;

    logic                 wr_ctrl, wr_period, wr_prescale, wr_ch_en, shadow_wr;
    logic [CH_COUNT-1:0]  wr_duty;
    logic                 tick, boundary, xfer, dir_next;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CH_COUNT-1:0]  pwm_next;

    // ---------------- bus decode ----------------
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ctrl     = avs_s0.write && (avs_s0.address == ADDR_CTRL);
        wr_period   = avs_s0.write && (avs_s0.address == ADDR_PERIOD);
        wr_prescale = avs_s0.write && (avs_s0.address == ADDR_PRESCALE);
        wr_ch_en    = avs_s0.write && (avs_s0.address == ADDR_CH_EN);
        wr_duty     = '0;
        for (int n = 0; n < CH_COUNT; n++) begin
            wr_duty[n] = avs_s0.write && (avs_s0.address == ADDR_DUTY0 + 8'(n));
        end
        shadow_wr = wr_period || (|wr_duty);
    end

    always_comb begin
        rd_mux = '0;
        case (avs_s0.address)
            ADDR_CTRL:     rd_mux[2:0]           = {inv, center, en};
            ADDR_PERIOD:   rd_mux[CNT_WIDTH-1:0] = period_sh;
            ADDR_PRESCALE: rd_mux[PRE_WIDTH-1:0] = prescale;
            ADDR_STATUS:   rd_mux[1:0]           = {dir_down, pending};
            ADDR_CH_EN:    rd_mux[CH_COUNT-1:0]  = ch_en;
            default:       ;
        endcase
        for (int n = 0; n < CH_COUNT; n++) begin
            if (avs_s0.address == ADDR_DUTY0 + 8'(n)) rd_mux[CNT_WIDTH-1:0] = duty_sh[n];
        end
    end

    // Read: one wait cycle captures the data, the second cycle presents it.
    always_comb begin
        rd_state_next = rd_state;
        rd_capture    = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (avs_s0.read && !avs_s0.write) begin
                    rd_capture    = 1'b1;
                    rd_state_next = RD_DATA;
                end
            end
            RD_DATA: rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    assign avs_s0.waitrequest = rd_capture;
    assign avs_s0.readdata    = readdata_q;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rd_state   <= RD_IDLE;
            readdata_q <= '0;
        end else begin
            rd_state <= rd_state_next;
            if (rd_capture) readdata_q <= rd_mux;
        end
    end

    // ---------------- register file and shadows ----------------
    assign xfer = pending && (boundary || !en);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            en        <= 1'b0;
            center    <= 1'b0;
            inv       <= 1'b0;
            period_sh <= '0;
            prescale  <= '0;
            ch_en     <= '0;
            pending   <= 1'b0;
            p_act     <= '0;
            // NOTE: the duty arrays are plain flops, not RAM, so they are reset with the rest.
            for (int n = 0; n < CH_COUNT; n++) begin
                duty_sh[n] <= '0;
                d_act[n]   <= '0;
            end
        end else begin
            if (wr_ctrl)     {inv, center, en} <= avs_s0.writedata[2:0];
            if (wr_period)   period_sh         <= avs_s0.writedata[CNT_WIDTH-1:0];
            if (wr_prescale) prescale          <= avs_s0.writedata[PRE_WIDTH-1:0];
            if (wr_ch_en)    ch_en             <= avs_s0.writedata[CH_COUNT-1:0];
            for (int n = 0; n < CH_COUNT; n++) begin
                if (wr_duty[n]) duty_sh[n] <= avs_s0.writedata[CNT_WIDTH-1:0];
            end
            // The transfer uses pre-edge shadows; a same-edge write stays pending.
            if (xfer) begin
                p_act <= period_sh;
                for (int n = 0; n < CH_COUNT; n++) d_act[n] <= duty_sh[n];
            end
            if (shadow_wr)  pending <= 1'b1;
            else if (xfer)  pending <= 1'b0;
        end
    end

    // ---------------- prescaler and period counter ----------------
    always_comb begin
        tick     = en && (pre_cnt == prescale);
        cnt_next = cnt;
        dir_next = dir_down;
        boundary = 1'b0;
        if (tick) begin
            if (!center_act) begin
                if (cnt >= p_act) begin
                    cnt_next = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end else if (!dir_down && (cnt < p_act)) begin
                cnt_next = cnt + CNT_ONE;
            end else if (cnt == '0) begin
                boundary = 1'b1;
            end else begin
                cnt_next = cnt - CNT_ONE;
                boundary = (cnt == CNT_ONE);
                dir_next = (cnt != CNT_ONE);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pre_cnt    <= '0;
            cnt        <= '0;
            dir_down   <= 1'b0;
            center_act <= 1'b0;
        end else begin
            if (!en || boundary) center_act <= center;
            if (!en) begin
                pre_cnt  <= '0;
                cnt      <= '0;
                dir_down <= 1'b0;
            end else begin
                pre_cnt  <= tick ? '0 : pre_cnt + PRE_ONE;
                cnt      <= cnt_next;
                dir_down <= dir_next;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        pwm_next = '0;
        for (int n = 0; n < CH_COUNT; n++) begin
            pwm_next[n] = en && ch_en[n] && ((cnt < d_act[n]) ^ inv);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pwm_out    <= '0;
            period_irq <= 1'b0;
        end else begin
            pwm_out    <= pwm_next;
            period_irq <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_multi_avs.sv
// Self-checking bench for pwm_multi_avs: directed steps plus randomized traffic,
// compared every cycle against a phase-based behavioural model.
module tb_pwm_multi_avs;
    localparam int CH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] pwm_out;
    logic          period_irq;

    pwm_multi_avs_if bus ();

    pwm_multi_avs #(.CH_COUNT(CH), .CNT_WIDTH(16), .PRE_WIDTH(16)) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .avs_s0     (bus),
        .pwm_out    (pwm_out),
        .period_irq (period_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: the counter is tracked as a tick phase within the period.
    bit           m_en, m_center, m_inv, m_cact, m_pending, m_irq;
    logic [15:0]  m_pre, m_prec;
    int unsigned  m_period, m_pact, m_phase;
    logic [7:0]   m_chen;
    int unsigned  m_duty [CH];
    int unsigned  m_dact [CH];
    logic [CH-1:0] m_pwm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_center = 0; m_inv = 0; m_cact = 0; m_pending = 0; m_irq = 0;
        m_pre = '0; m_prec = '0; m_period = 0; m_pact = 0; m_phase = 0;
        m_chen = '0; m_pwm = '0;
        for (int n = 0; n < CH; n++) begin
            m_duty[n] = 0;
            m_dact[n] = 0;
        end
    endtask

    function automatic int unsigned cur_cnt();
        if (!m_cact || m_phase <= m_pact) return m_phase;
        return 2 * m_pact - m_phase;
    endfunction

    function automatic logic [31:0] model_rd(input logic [7:0] a);
        logic [31:0] v;
        int idx;
        v = '0;
        idx = int'(a) - 16;
        if (a == 8'h00)      v = {29'd0, m_inv, m_center, m_en};
        else if (a == 8'h01) v = m_period;
        else if (a == 8'h02) v = {16'd0, m_pre};
        else if (a == 8'h03) v = {30'd0, (m_cact && (m_phase > m_pact)), m_pending};
        else if (a == 8'h04) v = {24'd0, m_chen};
        else if (idx >= 0 && idx < CH) v = m_duty[idx];
        return v;
    endfunction

    // Advance one clock: evaluate the model on pre-edge state/inputs, then compare.
    task automatic cycle();
        logic          tick, bnd, xfer, wsh, w, r;
        logic [7:0]    a;
        logic [31:0]   wd;
        int unsigned   len, cnt, nphase;
        int            idx;
        logic [CH-1:0] npwm;
        a = bus.address; wd = bus.writedata; w = bus.write; r = rst;
        idx = int'(a) - 16;
        cnt = cur_cnt();
        tick = m_en && (m_prec == m_pre);
        bnd = 0;
        nphase = m_phase;
        if (tick) begin
            len = m_cact ? ((m_pact == 0) ? 1 : 2 * m_pact) : m_pact + 1;
            nphase = (m_phase + 1) % len;
            bnd = (nphase == 0);
        end
        for (int n = 0; n < CH; n++) npwm[n] = m_en && m_chen[n] && ((cnt < m_dact[n]) ^ m_inv);
        xfer = m_pending && (bnd || !m_en);
        wsh = w && (a == 8'h01 || (idx >= 0 && idx < CH));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            m_pwm = npwm;
            m_irq = bnd;
            if (xfer) begin
                m_pact = m_period;
                for (int n = 0; n < CH; n++) m_dact[n] = m_duty[n];
            end
            if (wsh) m_pending = 1;
            else if (xfer) m_pending = 0;
            if (!m_en || bnd) m_cact = m_center;
            if (!m_en) begin
                m_phase = 0;
                m_prec = '0;
            end else if (tick) begin
                m_prec = '0;
                m_phase = nphase;
            end else begin
                m_prec = m_prec + 16'd1;
            end
            if (w) begin
                if (a == 8'h00) begin
                    m_en = wd[0]; m_center = wd[1]; m_inv = wd[2];
                end
                else if (a == 8'h01) m_period = {16'd0, wd[15:0]};
                else if (a == 8'h02) m_pre = wd[15:0];
                else if (a == 8'h04) m_chen = wd[7:0];
                else if (idx >= 0 && idx < CH) m_duty[idx] = {16'd0, wd[15:0]};
            end
        end
        #1;
        check("pwm_out", {24'd0, pwm_out}, {24'd0, m_pwm});
        check("period_irq", {31'd0, period_irq}, {31'd0, m_irq});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.address = a;
        bus.writedata = d;
        bus.write = 1'b1;
        cycle();
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        logic [31:0] exp;
        bus.address = a;
        bus.read = 1'b1;
        #1;
        check("waitrequest_first", {31'd0, bus.waitrequest}, 32'd1);
        exp = model_rd(a);
        cycle();
        check("waitrequest_second", {31'd0, bus.waitrequest}, 32'd0);
        check("readdata", bus.readdata, exp);
        d = bus.readdata;
        bus.read = 1'b0;
        cycle();
        check("readdata_hold", bus.readdata, exp);
    endtask

    task automatic run_count(input int n, output int h0, output int h1, output int irqs);
        h0 = 0; h1 = 0; irqs = 0;
        repeat (n) begin
            cycle();
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            irqs += int'(period_irq);
        end
    endtask

    initial begin
        logic [31:0] d;
        int h0, h1, irqs, p, sel;
        bit found;

        model_reset();
        rst = 1'b1;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_pwm", {24'd0, pwm_out}, 32'd0);
        check("reset_irq", {31'd0, period_irq}, 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_waitrequest", {31'd0, bus.waitrequest}, 32'd0);

        // Register access
        wr(8'h04, 32'hFF);
        rd(8'h04, d);
        check("ch_en_read", d, 32'h0000_00FF);
        rd(8'h07, d);
        check("unmapped_read", d, 32'd0);

        // Simultaneous read and write: write wins, readdata untouched
        bus.address = 8'h02; bus.writedata = 32'd0; bus.read = 1'b1; bus.write = 1'b1;
        #1;
        check("rw_waitrequest", {31'd0, bus.waitrequest}, 32'd0);
        cycle();
        bus.read = 1'b0; bus.write = 1'b0;
        check("rw_readdata_kept", bus.readdata, 32'd0);

        // Edge mode: 3 of 10 high
        wr(8'h02, 32'd0);
        wr(8'h01, 32'd9);
        wr(8'h10, 32'd3);
        wr(8'h00, 32'd1);
        repeat (20) cycle();
        run_count(10, h0, h1, irqs);
        check("edge_high_count", h0, 32'd3);
        check("edge_irq_count", irqs, 32'd1);

        // Shadow update mid-period
        repeat (4) cycle();
        wr(8'h10, 32'd7);
        rd(8'h03, d);
        check("status_pending", d, 32'd1);
        repeat (20) cycle();
        run_count(10, h0, h1, irqs);
        check("shadow_high_count", h0, 32'd7);
        rd(8'h03, d);
        check("status_cleared", d, 32'd0);

        // Center mode with prescale
        wr(8'h00, 32'd0);
        wr(8'h01, 32'd4);
        wr(8'h11, 32'd2);
        wr(8'h02, 32'd1);
        wr(8'h00, 32'd3);
        repeat (40) cycle();
        run_count(16, h0, h1, irqs);
        check("center_irq_count", irqs, 32'd1);
        run_count(16, h0, h1, irqs);
        check("center_irq_count2", irqs, 32'd1);

        // Limits: zero duty, duty above period, inversion, disabled channel
        wr(8'h00, 32'd0);
        wr(8'h02, 32'd0);
        wr(8'h01, 32'd9);
        wr(8'h10, 32'd0);
        wr(8'h11, 32'd10);
        wr(8'h00, 32'd1);
        repeat (12) cycle();
        run_count(10, h0, h1, irqs);
        check("duty0_low", h0, 32'd0);
        check("duty_over_high", h1, 32'd10);
        wr(8'h00, 32'd5);
        repeat (2) cycle();
        run_count(10, h0, h1, irqs);
        check("inv_duty0_high", h0, 32'd10);
        check("inv_duty_over_low", h1, 32'd0);
        wr(8'h04, 32'hFE);
        repeat (2) cycle();
        run_count(10, h0, h1, irqs);
        check("disabled_ch_low", h0, 32'd0);

        // Randomized traffic against the model
        for (int r = 0; r < 24; r++) begin
            wr(8'h00, 32'd0);
            wr(8'h02, $urandom_range(0, 3));
            p = int'($urandom_range(0, 20));
            wr(8'h01, p);
            for (int n = 0; n < CH; n++) wr(8'(16 + n), $urandom_range(0, p + 2));
            wr(8'h04, $urandom_range(0, 255));
            wr(8'h00, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
            for (int k = 0; k < 150; k++) begin
                sel = int'($urandom_range(0, 19));
                case (sel)
                    0: wr(8'h01, $urandom_range(0, 20));
                    1: wr(8'(16 + $urandom_range(0, CH - 1)), $urandom_range(0, 22));
                    2: rd(8'($urandom_range(0, 31)), d);
                    3: wr(8'h00, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
                    4: wr($urandom_range(0, 1) ? 8'($urandom_range(5, 15)) : 8'($urandom_range(24, 255)),
                          $urandom);
                    default: cycle();
                endcase
            end
        end

        // Reset during a high phase
        wr(8'h00, 32'd0);
        wr(8'h02, 32'd0);
        wr(8'h01, 32'd9);
        wr(8'h10, 32'd5);
        wr(8'h04, 32'hFF);
        wr(8'h00, 32'd1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = pwm_out[0];
        end
        check("wait_high_phase", {31'd0, found}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid_pwm", {24'd0, pwm_out}, 32'd0);
        check("rst_mid_irq", {31'd0, period_irq}, 32'd0);
        check("rst_mid_readdata", bus.readdata, 32'd0);
        for (int a = 0; a < 5; a++) begin
            rd(8'(a), d);
            check("rst_reg_zero", d, 32'd0);
        end
        rd(8'h10, d);
        check("rst_duty_zero", d, 32'd0);
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
